multicycle_control: RTL and testbench



---
 rtl/mc_pkg.sv | 50 +++++
 rtl/mc_wait_timer.sv | 31 +++
 rtl/multicycle_control.sv | 134 +++++++++++++
 tb/tb_multicycle_control.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// Also holds the opcode dispatch table used in DECODE.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_JALR_LINK
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] A1_PC     = 2'b00;
    localparam logic [1:0] A1_OLDPC  = 2'b01;
    localparam logic [1:0] A1_RS1    = 2'b10;
    localparam logic [1:0] A1_ZERO   = 2'b11;
    localparam logic [1:0] A2_RS2    = 2'b00;
    localparam logic [1:0] A2_IMM    = 2'b01;
    localparam logic [1:0] A2_FOUR   = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] RWS_ALUOUT = 2'b00;
    localparam logic [1:0] RWS_MEM    = 2'b01;
    localparam logic [1:0] RWS_ALU    = 2'b10;

    // S_FETCH doubles as the "unsupported opcode" answer.
    function automatic state_t dispatch(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_R:              return S_EXECR;
            OP_I:              return S_EXECI;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            OP_AUIPC:          return S_AUIPC;
            default:           return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating count of consecutive memory wait cycles; flags timeout on the
// WAIT_LIMIT-th wait cycle (WAIT_LIMIT = 0 disables the timeout).
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_cyc,
    output logic timeout
);

    localparam int CW     = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam int LIM_M1 = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;

    logic [CW-1:0] cnt;

    // cnt holds the number of earlier wait cycles, so the compare fires on the
    // WAIT_LIMIT-th one. Leaving a memory state always coincides with a
    // non-wait cycle or a timeout, so both clear the count.
    assign timeout = (WAIT_LIMIT != 0) && wait_cyc && (cnt == LIM_M1[CW-1:0]);

    always_ff @(posedge clk) begin
        if (reset || !wait_cyc || timeout)
            cnt <= '0;
        else if (cnt != {CW{1'b1}})
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM with Moore-decoded datapath strobes.
// Define MC_PERF_COUNTERS_EN to add cycle_cnt / retired_cnt outputs.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opCode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adrSrc,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       branch,
    output logic       RAMwe,
    output logic       Regwe,
    output logic [1:0] ALUSrc1,
    output logic [1:0] ALUSrc2,
    output logic [1:0] ALUOp,
    output logic [1:0] RegWriteSrc,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    state_t cur;

    assign state = cur;

    mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .wait_cyc (mem_req && !mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_IDLE;
        end else begin
            case (cur)
                S_IDLE:      cur <= S_FETCH;
                S_FETCH:     if (mem_ready) cur <= S_DECODE;
                S_DECODE:    cur <= dispatch(opCode);
                S_MEMADR:    cur <= (opCode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:   if (mem_ready) cur <= S_MEMWB;
                             else if (timeout) cur <= S_FETCH;
                S_MEMWRITE:  if (mem_ready || timeout) cur <= S_FETCH;
                S_JALR:      cur <= S_JALR_LINK;
                S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL, S_JALR_LINK:
                             cur <= S_ALUWB;
                default:     cur <= S_FETCH;
            endcase
        end
    end

    // Outputs depend on the state; mem_ready only qualifies the fetch
    // strobes and opCode only the illegal flag.
    always_comb begin
        mem_req     = 1'b0;
        adrSrc      = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        branch      = 1'b0;
        RAMwe       = 1'b0;
        Regwe       = 1'b0;
        ALUSrc1     = A1_PC;
        ALUSrc2     = A2_RS2;
        ALUOp       = ALU_ADD;
        RegWriteSrc = RWS_ALUOUT;
        illegal     = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrc2 = A2_FOUR;
                if (mem_ready) begin
                    irWrite     = 1'b1;
                    pcWrite     = 1'b1;
                    RegWriteSrc = RWS_ALU;
                end
            end
            S_DECODE: begin
                ALUSrc1 = A1_OLDPC;
                ALUSrc2 = A2_IMM;
                illegal = (dispatch(opCode) == S_FETCH);
            end
            S_MEMADR:    begin ALUSrc1 = A1_RS1; ALUSrc2 = A2_IMM; end
            S_MEMREAD:   begin mem_req = 1'b1; adrSrc = 1'b1; end
            S_MEMWB:     begin Regwe = 1'b1; RegWriteSrc = RWS_MEM; end
            S_MEMWRITE:  begin mem_req = 1'b1; adrSrc = 1'b1; RAMwe = 1'b1; end
            S_EXECR:     begin ALUSrc1 = A1_RS1; ALUOp = ALU_FUNCT; end
            S_EXECI:     begin ALUSrc1 = A1_RS1; ALUSrc2 = A2_IMM; ALUOp = ALU_FUNCT; end
            S_LUI:       begin ALUSrc1 = A1_ZERO; ALUSrc2 = A2_IMM; end
            S_AUIPC:     begin ALUSrc1 = A1_OLDPC; ALUSrc2 = A2_IMM; end
            S_ALUWB:     Regwe = 1'b1;
            S_BRANCH:    begin ALUSrc1 = A1_RS1; ALUOp = ALU_SUB; branch = 1'b1; end
            S_JAL:       begin ALUSrc1 = A1_OLDPC; ALUSrc2 = A2_FOUR; pcWrite = 1'b1; end
            S_JALR: begin
                ALUSrc1     = A1_RS1;
                ALUSrc2     = A2_IMM;
                pcWrite     = 1'b1;
                RegWriteSrc = RWS_ALU;
            end
            S_JALR_LINK: begin ALUSrc1 = A1_OLDPC; ALUSrc2 = A2_FOUR; end
            default: ;
        endcase
    end

`ifdef MC_PERF_COUNTERS_EN
    logic retire;

    // Normal completions only; illegal and timeout exits never land here.
    assign retire = (cur == S_MEMWB) || (cur == S_ALUWB) || (cur == S_BRANCH) ||
                    ((cur == S_MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (cur != S_IDLE) cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed + randomized bench; a route-per-opcode model predicts every output.
module tb_multicycle_control;

    localparam int WL = 4;
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMREAD = 4,
                   S_MEMWB = 5, S_MEMWRITE = 6, S_EXECR = 7, S_EXECI = 8, S_LUI = 9,
                   S_AUIPC = 10, S_ALUWB = 11, S_BRANCH = 12, S_JAL = 13, S_JALR = 14,
                   S_LINK = 15;

    logic       clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
    logic [6:0] opCode = 7'd0;
    logic       mem_req, adrSrc, irWrite, pcWrite, branch, RAMwe, Regwe, illegal, timeout;
    logic [1:0] ALUSrc1, ALUSrc2, ALUOp, RegWriteSrc;
    logic [3:0] state;
`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_cnt, retired_cnt;
    logic [31:0] m_cyc = 0, m_ret = 0;
`endif

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
        .mem_req(mem_req), .adrSrc(adrSrc), .irWrite(irWrite), .pcWrite(pcWrite),
        .branch(branch), .RAMwe(RAMwe), .Regwe(Regwe), .ALUSrc1(ALUSrc1),
        .ALUSrc2(ALUSrc2), .ALUOp(ALUOp), .RegWriteSrc(RegWriteSrc),
        .illegal(illegal), .timeout(timeout), .state(state)
`ifdef MC_PERF_COUNTERS_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
    );

    logic [20:0] act_vec;
    assign act_vec = {state, mem_req, adrSrc, irWrite, pcWrite, branch, RAMwe, Regwe,
                      ALUSrc1, ALUSrc2, ALUOp, RegWriteSrc, illegal, timeout};

    int errs = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    // Expected output bundle for one cycle of a given step.
    function automatic logic [20:0] exp_vec(input int st, input logic [6:0] op,
                                            input logic rdy, input int w);
        logic mq, ad, ir, pw, br, we, rw, il, to;
        logic [1:0] a1, a2, ao, rs;
        logic [3:0] s4;
        {mq, ad, ir, pw, br, we, rw, il, to} = '0;
        {a1, a2, ao, rs} = '0;
        case (st)
            S_FETCH:    begin mq = 1; a2 = 2; if (rdy) begin ir = 1; pw = 1; rs = 2; end end
            S_DECODE:   begin a1 = 1; a2 = 1; il = !is_legal(op); end
            S_MEMADR:   begin a1 = 2; a2 = 1; end
            S_MEMREAD:  begin mq = 1; ad = 1; end
            S_MEMWB:    begin rw = 1; rs = 1; end
            S_MEMWRITE: begin mq = 1; ad = 1; we = 1; end
            S_EXECR:    begin a1 = 2; ao = 2; end
            S_EXECI:    begin a1 = 2; a2 = 1; ao = 2; end
            S_LUI:      begin a1 = 3; a2 = 1; end
            S_AUIPC:    begin a1 = 1; a2 = 1; end
            S_ALUWB:    rw = 1;
            S_BRANCH:   begin a1 = 2; ao = 1; br = 1; end
            S_JAL:      begin a1 = 1; a2 = 2; pw = 1; end
            S_JALR:     begin a1 = 2; a2 = 1; pw = 1; rs = 2; end
            S_LINK:     begin a1 = 1; a2 = 2; end
            default: ;
        endcase
        if (mq && !rdy && (w + 1 == WL)) to = 1;
        s4 = 4'(st);
        return {s4, mq, ad, ir, pw, br, we, rw, a1, a2, ao, rs, il, to};
    endfunction

    // Model: current step, remaining route of the instruction, wait count.
    int  m_st = 0, m_wait = 0;
    int  route[$];
    bit  m_ok = 0;

    task automatic advance();
        if (route.size() == 0) begin
            m_st = S_FETCH;
`ifdef MC_PERF_COUNTERS_EN
            m_ret++;
`endif
        end else begin
            m_st = route.pop_front();
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            chk("outputs", 32'(act_vec), 32'(exp_vec(m_st, opCode, mem_ready, m_wait)));
`ifdef MC_PERF_COUNTERS_EN
            chk("cycle_cnt", cycle_cnt, m_cyc);
            chk("retired_cnt", retired_cnt, m_ret);
`endif
        end
        if (reset) begin
            m_st = S_IDLE; m_wait = 0; route.delete(); m_ok = 1;
`ifdef MC_PERF_COUNTERS_EN
            m_cyc = 0; m_ret = 0;
`endif
        end else if (m_ok) begin
`ifdef MC_PERF_COUNTERS_EN
            if (m_st != S_IDLE) m_cyc++;
`endif
            case (m_st)
                S_IDLE: m_st = S_FETCH;
                S_DECODE: begin
                    route.delete();
                    case (opCode)
                        7'b0000011: route = '{S_MEMADR, S_MEMREAD, S_MEMWB};
                        7'b0100011: route = '{S_MEMADR, S_MEMWRITE};
                        7'b0110011: route = '{S_EXECR, S_ALUWB};
                        7'b0010011: route = '{S_EXECI, S_ALUWB};
                        7'b1100011: route = '{S_BRANCH};
                        7'b1101111: route = '{S_JAL, S_ALUWB};
                        7'b1100111: route = '{S_JALR, S_LINK, S_ALUWB};
                        7'b0110111: route = '{S_LUI, S_ALUWB};
                        7'b0010111: route = '{S_AUIPC, S_ALUWB};
                        default: ;
                    endcase
                    if (route.size() == 0) m_st = S_FETCH;
                    else m_st = route.pop_front();
                end
                S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                    if (mem_ready) begin
                        m_wait = 0;
                        if (m_st == S_FETCH) m_st = S_DECODE;
                        else advance();
                    end else begin
                        m_wait++;
                        if (m_wait == WL) begin
                            m_wait = 0; route.delete(); m_st = S_FETCH;
                        end
                    end
                end
                default: advance();
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    initial begin
        int p_rdy;
        // Reset held three cycles: everything quiet, IDLE.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_state", 32'(state), S_IDLE);
            chk("rst_outs", 32'(act_vec[16:0]), 0);
        end
        reset = 0; opCode = 7'b0110011; mem_ready = 1;
        tick(); chk("r_fetch", 32'(state), S_FETCH); chk("r_memreq", 32'(mem_req), 1);
        tick(); chk("r_decode", 32'(state), S_DECODE);
        tick(); chk("r_execr", 32'(state), S_EXECR); chk("r_execr_we", 32'(Regwe), 0);
        tick(); chk("r_aluwb", 32'(state), S_ALUWB); chk("r_aluwb_we", 32'(Regwe), 1);
        chk("r_aluwb_rws", 32'(RegWriteSrc), 0);
        tick(); chk("r_back", 32'(state), S_FETCH);
        // Load with three wait cycles in MEMREAD.
        opCode = 7'b0000011;
        tick(); tick(); chk("lw_memadr", 32'(state), S_MEMADR);
        mem_ready = 0;
        tick(); chk("lw_rd1", 32'(state), S_MEMREAD); chk("lw_adr", 32'(adrSrc), 1);
        tick(); tick(); tick(); chk("lw_rd4", 32'(state), S_MEMREAD);
        mem_ready = 1;
        tick(); chk("lw_wb", 32'(state), S_MEMWB); chk("lw_wb_we", 32'(Regwe), 1);
        chk("lw_wb_rws", 32'(RegWriteSrc), 1);
        tick(); chk("lw_back", 32'(state), S_FETCH);
        // Store.
        opCode = 7'b0100011;
        tick(); tick(); chk("sw_memadr_we", 32'(RAMwe), 0);
        tick(); chk("sw_write", 32'(state), S_MEMWRITE);
        chk("sw_ramwe", 32'(RAMwe), 1); chk("sw_adr", 32'(adrSrc), 1);
        chk("sw_regwe", 32'(Regwe), 0);
        tick(); chk("sw_back", 32'(state), S_FETCH);
        // Illegal opcode.
        opCode = 7'b1111111;
        tick(); chk("ill_decode", 32'(state), S_DECODE); chk("ill_pulse", 32'(illegal), 1);
        tick(); chk("ill_fetch", 32'(state), S_FETCH); chk("ill_clear", 32'(illegal), 0);
        // Fetch timeout on the fourth wait cycle.
        mem_ready = 0; #1;
        chk("to_w1", 32'(timeout), 0);
        tick(); tick(); tick();
        chk("to_w4", 32'(timeout), 1); chk("to_w4_st", 32'(state), S_FETCH);
        tick(); chk("to_after", 32'(timeout), 0); chk("to_refetch", 32'(state), S_FETCH);
        // Reset in the middle of a load's memory wait.
        mem_ready = 1; opCode = 7'b0000011;
        tick(); tick(); mem_ready = 0;
        tick(); chk("rst_mid_rd", 32'(state), S_MEMREAD);
        reset = 1;
        tick(); chk("rst_mid_idle", 32'(state), S_IDLE); chk("rst_mid_outs", 32'(act_vec[16:0]), 0);
        reset = 0;

        // Randomized traffic; opCode only changes while fetching.
        p_rdy = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) p_rdy = $urandom_range(30, 95);
            reset = ($urandom_range(0, 299) == 0);
            mem_ready = ($urandom_range(0, 99) < p_rdy);
            if (m_st == S_FETCH || m_st == S_IDLE) begin
                if ($urandom_range(0, 9) == 0) opCode = 7'($urandom);
                else opCode = ops[$urandom_range(0, 8)];
            end
            tick();
        end
        reset = 0;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
